// File: rtl/musb_div_pkg.sv
// Shared definitions for the divide sequencer and its HI/LO register pair.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package musb_div_pkg;

  // Sequencer states; encodings are fixed so waveforms and debug tools agree.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DIVZ  = 2'd3
  } state_t;

  // LO value written when the divisor is zero and no exception is raised.
  localparam logic [31:0] DIVZ_QUOTIENT = 32'hFFFF_FFFF;

  // The divider returns an unsigned remainder magnitude; the MIPS remainder
  // takes the sign of the dividend, so negate it when the dividend was negative.
  function automatic logic [31:0] fix_remainder(input logic neg, input logic [31:0] mag);
    return neg ? (32'd0 - mag) : mag;
  endfunction

endpackage

// File: rtl/musb_hilo.sv
// HI/LO register pair: MTHI/MTLO writes take priority over divide results per register.
// Latency: one cycle from write enable to register output.
// Backpressure: none; writes are accepted every cycle.
module musb_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] mt_data,
  input  logic        res_we,
  input  logic [31:0] res_hi,
  input  logic [31:0] res_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // HI register: a move-to write beats a coincident divide result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= 32'd0;
    end else if (hi_we) begin
      hi <= mt_data;
    end else if (res_we) begin
      hi <= res_hi;
    end
  end

  // LO register: same priority as HI, decided independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo <= 32'd0;
    end else if (lo_we) begin
      lo <= mt_data;
    end else if (res_we) begin
      lo <= res_lo;
    end
  end

endmodule

// File: rtl/musb_div_ctrl.sv
// Divide sequencer: accepts DIV/DIVU, pulses the divider start, captures HI/LO (MUSB_DIV_ZERO_EXC_EN raises exc on /0).
// Latency: result and done 35 cycles after accept; divide-by-zero resolves in 2 cycles.
// Backpressure: req_ready only in IDLE without flush; flush cancels the in-flight op with no write.
module musb_div_ctrl
  import musb_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] mt_data,
  output logic        div_op_divs,
  output logic        div_op_divu,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        exc_div_zero
);

  state_t      state, state_nxt;
  logic [31:0] a_q, b_q;
  logic        signed_q, sign_a_q;
  logic        done_q, done_d;
  logic        res_we;
  logic [31:0] res_hi, res_lo;
  logic        accept;

  // Reset gating keeps the request side closed while the block is held in reset.
  assign req_ready    = rst && (state == IDLE) && !flush;
  assign accept       = req_valid && req_ready;
  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign div_dividend = a_q;
  assign div_divisor  = b_q;

`ifdef MUSB_DIV_ZERO_EXC_EN
  logic exc_q, exc_d;
  assign exc_div_zero = exc_q;
`else
  assign exc_div_zero = 1'b0;
`endif

  // Capture operands and dividend sign on the accept handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
    end else if (accept) begin
      a_q      <= req_a;
      b_q      <= req_b;
      signed_q <= req_signed;
      sign_a_q <= req_signed && req_a[31];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Completion pulses are registered so they line up with the new HI/LO values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
`ifdef MUSB_DIV_ZERO_EXC_EN
      exc_q  <= 1'b0;
`endif
    end else begin
      done_q <= done_d;
`ifdef MUSB_DIV_ZERO_EXC_EN
      exc_q  <= exc_d;
`endif
    end
  end

  // Next-state, divider start pulse and result-write decode.
  always_comb begin
    state_nxt   = state;
    div_op_divs = 1'b0;
    div_op_divu = 1'b0;
    res_we      = 1'b0;
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    done_d      = 1'b0;
`ifdef MUSB_DIV_ZERO_EXC_EN
    exc_d       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (req_b == 32'd0) ? DIVZ : START;
        end
      end
      START: begin
        // The start pulse fires even if flushed; the divider is simply restarted later.
        div_op_divs = signed_q;
        div_op_divu = !signed_q;
        state_nxt   = flush ? IDLE : WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (!div_stall) begin
          res_we    = 1'b1;
          res_lo    = div_quotient;
          res_hi    = fix_remainder(sign_a_q, div_remainder);
          done_d    = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIVZ: begin
        state_nxt = IDLE;
        if (!flush) begin
`ifdef MUSB_DIV_ZERO_EXC_EN
          exc_d  = 1'b1;
`else
          res_we = 1'b1;
          res_lo = DIVZ_QUOTIENT;
          res_hi = a_q;
          done_d = 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  musb_hilo u_hilo (
    .clk     (clk),
    .rst     (rst),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .mt_data (mt_data),
    .res_we  (res_we),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .hi      (hi),
    .lo      (lo)
  );

endmodule

// File: tb/tb_musb_div_ctrl.sv
// Bench for musb_div_ctrl: behavioural divider, cycle-level reference model, directed and random stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_musb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_signed = 1'b0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic        req_ready;
  logic        flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] mt_data = 32'd0;
  logic        div_op_divs, div_op_divu;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_quotient, div_remainder;
  logic        div_stall;
  logic [31:0] hi, lo;
  logic        busy, done, exc_div_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  musb_div_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .mt_data(mt_data),
    .div_op_divs(div_op_divs), .div_op_divu(div_op_divu),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_stall(div_stall),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .exc_div_zero(exc_div_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Divider stand-in: 32 busy cycles after a start pulse, magnitude-based remainder.
  logic [5:0]  dv_cnt = 6'd0;
  logic [31:0] dv_q = 32'd0, dv_r = 32'd0;
  logic [31:0] ma, mb, qm;
  logic        sg;
  assign div_stall     = (dv_cnt != 6'd0);
  assign div_quotient  = dv_q;
  assign div_remainder = dv_r;

  always @(posedge clk) begin
    if (div_op_divs || div_op_divu) begin
      sg = div_op_divs;
      ma = (sg && div_dividend[31]) ? -div_dividend : div_dividend;
      mb = (sg && div_divisor[31])  ? -div_divisor  : div_divisor;
      qm = (mb == 32'd0) ? 32'd0 : ma / mb;
      dv_q   <= (sg && (div_dividend[31] ^ div_divisor[31])) ? -qm : qm;
      dv_r   <= (mb == 32'd0) ? 32'd0 : ma % mb;
      dv_cnt <= 6'd32;
    end else if (dv_cnt != 6'd0) begin
      dv_cnt <= dv_cnt - 6'd1;
    end
  end

  // Architectural result: 64-bit truncating division, remainder signed like the dividend.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    logic [63:0] vq, vr;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (sb == 0) begin
      q = 32'd0; r = 32'd0;
    end else begin
      lq = sa / sb; lr = sa % sb;
      vq = lq; vr = lr;
      q = vq[31:0]; r = vr[31:0];
    end
  endfunction

  // Reference model in cycle offsets from the accept cycle; compared every cycle.
  int          n = 0;
  int          m_kind = 0;  // 0 idle, 1 divide in flight, 2 divide-by-zero
  int          m_acc = 0;
  logic        m_s = 1'b0, m_done = 1'b0, m_exc = 1'b0, exp_op, nd, ne;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_hi = 32'd0, m_lo = 32'd0;
  logic [31:0] r_hi = 32'd0, r_lo = 32'd0, nhi, nlo;

  always @(negedge clk) begin
    if (!rst) begin
      m_kind = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_exc = 1'b0;
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_done",  {31'd0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_ops", {30'd0, div_op_divs, div_op_divu}, 32'd0);
    end else begin
      exp_op = (m_kind == 1) && (n == m_acc + 1);
      chk("m_busy",  {31'd0, busy}, {31'd0, m_kind != 0});
      chk("m_ready", {31'd0, req_ready}, {31'd0, (m_kind == 0) && !flush});
      chk("m_done",  {31'd0, done}, {31'd0, m_done});
      chk("m_exc",   {31'd0, exc_div_zero}, {31'd0, m_exc});
      chk("m_hi", hi, m_hi);
      chk("m_lo", lo, m_lo);
      chk("m_divs", {31'd0, div_op_divs}, {31'd0, exp_op && m_s});
      chk("m_divu", {31'd0, div_op_divu}, {31'd0, exp_op && !m_s});
      if (exp_op) begin
        chk("m_dividend", div_dividend, m_a);
        chk("m_divisor",  div_divisor,  m_b);
      end
      nd = 1'b0; ne = 1'b0; nhi = m_hi; nlo = m_lo;
      if (m_kind != 0) begin
        if (flush) begin
          m_kind = 0;
        end else if (m_kind == 1 && n == m_acc + 34) begin
          nlo = r_lo; nhi = r_hi; nd = 1'b1; m_kind = 0;
        end else if (m_kind == 2) begin
`ifdef MUSB_DIV_ZERO_EXC_EN
          ne = 1'b1;
`else
          nlo = 32'hFFFF_FFFF; nhi = m_a; nd = 1'b1;
`endif
          m_kind = 0;
        end
      end else if (req_valid && !flush) begin
        m_acc = n; m_a = req_a; m_b = req_b; m_s = req_signed;
        m_kind = (req_b == 32'd0) ? 2 : 1;
        ref_div(req_signed, req_a, req_b, r_lo, r_hi);
      end
      if (hi_we) nhi = mt_data;
      if (lo_we) nlo = mt_data;
      m_hi = nhi; m_lo = nlo; m_done = nd; m_exc = ne;
    end
    n++;
  end

  // One request; records first done/exc cycle (relative to accept) and start pulses seen.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int flush_k, input int mt_k, input logic [31:0] mt_v,
                        output int lat, output logic exc_seen, output int ops);
    @(posedge clk); #1;
    chk("ready_at_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_signed = s; req_a = a; req_b = b;
    lat = -1; exc_seen = 1'b0; ops = 0;
    for (int k = 1; k < 60; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush = (k == flush_k);
      lo_we = (k == mt_k);
      mt_data = mt_v;
      if (div_op_divs || div_op_divu) ops++;
      if (lat < 0 && (done || exc_div_zero)) begin
        lat = k; exc_seen = exc_div_zero;
      end
    end
    flush = 1'b0; lo_we = 1'b0;
  endtask

  int   lat, ops;
  logic ex;
  int   r;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 0, 0, 32'd0, lat, ex, ops);
    chk("divu_lat", lat, 32'd35); chk("divu_ops", ops, 32'd1);
    chk("divu_lo", lo, 32'd14);   chk("divu_hi", hi, 32'd2);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'd0, lat, ex, ops);
    chk("div_neg_a_lo", lo, 32'hFFFF_FFFD); chk("div_neg_a_hi", hi, 32'hFFFF_FFFF);

    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0, 32'd0, lat, ex, ops);
    chk("div_neg_b_lo", lo, 32'hFFFF_FFFD); chk("div_neg_b_hi", hi, 32'd1);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, lat, ex, ops);
    chk("div_ovf_lo", lo, 32'h8000_0000); chk("div_ovf_hi", hi, 32'd0);

    run_op(1'b0, 32'd5, 32'd0, 0, 0, 32'd0, lat, ex, ops);
    chk("divz_lat", lat, 32'd2); chk("divz_ops", ops, 32'd0);
`ifdef MUSB_DIV_ZERO_EXC_EN
    chk("divz_exc", {31'd0, ex}, 32'd1);
    chk("divz_lo", lo, 32'h8000_0000); chk("divz_hi", hi, 32'd0);
`else
    chk("divz_exc", {31'd0, ex}, 32'd0);
    chk("divz_lo", lo, 32'hFFFF_FFFF); chk("divz_hi", hi, 32'd5);
`endif

    run_op(1'b0, 32'd100, 32'd7, 10, 0, 32'd0, lat, ex, ops);
    chk("flush_no_done", lat, 32'hFFFF_FFFF);
    run_op(1'b0, 32'd9, 32'd3, 0, 0, 32'd0, lat, ex, ops);
    chk("after_flush_lat", lat, 32'd35);
    chk("after_flush_lo", lo, 32'd3); chk("after_flush_hi", hi, 32'd0);

    run_op(1'b0, 32'd100, 32'd7, 0, 34, 32'h1234, lat, ex, ops);
    chk("mtlo_lat", lat, 32'd35);
    chk("mtlo_lo", lo, 32'h1234); chk("mtlo_hi", hi, 32'd2);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      req_valid  = ($urandom_range(0, 1) == 1);
      req_signed = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 7);
      req_a = (r == 0) ? 32'h8000_0000 : $urandom;
      r = $urandom_range(0, 7);
      req_b = (r == 0) ? 32'd0 : (r == 1) ? 32'($urandom_range(1, 9)) :
              (r == 2) ? 32'hFFFF_FFFF : $urandom;
      flush   = ($urandom_range(0, 39) == 0);
      hi_we   = ($urandom_range(0, 29) == 0);
      lo_we   = ($urandom_range(0, 29) == 0);
      mt_data = $urandom;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/musb_div_ctrl.md
Name: musb_div_ctrl

Overview:
Sequencer between the execute stage and the multi-cycle divider (musb_div). It accepts DIV/DIVU requests with a valid/ready handshake and pulses the divider's start input for exactly one cycle. It waits on the divider's stall, applies the signed-remainder fix-up and writes the HI/LO registers. It also owns the divide-by-zero shortcut, pipeline-flush cancellation and MTHI/MTLO writes.

Parameters:
None; widths are fixed at 32 (MIPS32).

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous assert, active-low (0 = reset)
req_valid  in  1  divide request
req_signed  in  1  1 = DIV, 0 = DIVU
req_a  in  32  dividend
req_b  in  32  divisor
req_ready  out  1  request accepted when req_valid && req_ready
flush  in  1  cancel the in-flight operation (pipeline kill)
hi_we  in  1  MTHI write
lo_we  in  1  MTLO write
mt_data  in  32  MTHI/MTLO data
div_op_divs  out  1  to divider op_divs
div_op_divu  out  1  to divider op_divu
div_dividend  out  32  to divider
div_divisor  out  32  to divider
div_quotient  in  32  from divider
div_remainder  in  32  from divider (unsigned magnitude)
div_stall  in  1  from divider (busy)
hi  out  32  HI register (remainder)
lo  out  32  LO register (quotient)
busy  out  1  1 while state != IDLE; the pipeline stalls MFHI/MFLO on it
done  out  1  one-cycle pulse, the cycle HI/LO first show a divide result
exc_div_zero  out  1  divide-by-zero pulse (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; hi=lo=0; done=0; busy=0; exc_div_zero=0.
  - div_op_* = 0; latched operands = 0; req_ready=0 while rst=0.
- States: IDLE, START, WAIT, DIVZ.
- req_ready = (state==IDLE) && !flush.
- IDLE:
  - On accept, latch a, b, signed and sign_a = req_signed && req_a[31].
  - If b == 0, go to DIVZ; otherwise go to START.
- START:
  - Drive div_op_divs=signed, div_op_divu=!signed for exactly this cycle; div_dividend/div_divisor come from the latches.
  - Go to WAIT.
- WAIT:
  - Stay while div_stall=1.
  - When div_stall=0, write lo=div_quotient and hi = sign_a ? -div_remainder : div_remainder (two's complement, 32-bit wrap).
  - Register done=1 for the next cycle and go to IDLE.
- DIVZ (feature off): lo=32'hFFFFFFFF, hi=a, done next cycle, go to IDLE.
- Latency:
  - Accept in cycle 0, START in cycle 1, divider iterates in cycles 2–33, stall low in cycle 34.
  - HI/LO update at the end of cycle 34; done=1 and req_ready=1 in cycle 35.
  - Divide-by-zero: done in cycle 2.
- Flush:
  - In START/WAIT/DIVZ, flush=1 returns to IDLE next cycle. No HI/LO write, no done.
  - If flush coincides with the WAIT capture cycle, flush wins.
  - The divider keeps running harmlessly; the next START pulse restarts it.
  - Flush in IDLE blocks acceptance that cycle.
- MTHI/MTLO:
  - hi_we/lo_we write in any state.
  - If one coincides with a result capture, the MT write wins for that register; the other register still takes the result.
- Signed overflow: -2^31 / -1 gives lo=32'h80000000, hi=0. This is the divider's natural result; no special case.
- done and exc_div_zero are never high in the same cycle.
- div_op_* are never high outside START.

Optional Feature:
Macro MUSB_DIV_ZERO_EXC_EN.
- Defined: DIVZ pulses exc_div_zero=1 for one cycle instead of done, and HI/LO are unchanged.
- Undefined: exc_div_zero is tied 0 and DIVZ writes the default values above.

Decomposition:
- Shared package musb_div_pkg:
  - state encoding localparams (IDLE=2'd0, START=2'd1, WAIT=2'd2, DIVZ=2'd3);
  - DIVZ_QUOTIENT=32'hFFFFFFFF.
- Natural sub-module: musb_hilo (HI/LO register pair with MT-priority write muxing), instantiated by musb_div_ctrl.
- The FSM stays in musb_div_ctrl.

Test Plan:
- DIVU 100/7, no flush -> lo=14, hi=2, done in exactly cycle 35 after accept, one-cycle START pulse on div_op_divu.
- DIV -7/2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIV 7/-2 -> lo=-3, hi=1.
- DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- DIVU 5/0 -> feature off: lo=32'hFFFFFFFF, hi=5, done in cycle 2. Feature on: exc_div_zero pulse, HI/LO unchanged, div_op_* never asserted.
- Flush in cycle 10 of DIVU 100/7, then DIVU 9/3 accepted -> no done for the first op; second op gives lo=3, hi=0 35 cycles after its accept.
- Reset mid-WAIT and MTLO(0x1234) coinciding with capture -> reset: all outputs 0 immediately, IDLE. MTLO case: lo=0x1234, hi=remainder.
